// File: rtl/nv_nvdla_csb_master_pkg.sv
// nv_nvdla_csb_master_pkg: shared constants and response layout for the CSB master csb2falcon FIFO
// Response payload: {is_write_ack, error, rdat[31:0]}.
package nv_nvdla_csb_master_pkg;
  localparam int CSB2FALCON_DEPTH     = 4;
  localparam int CSB2FALCON_WIDTH     = 34;
  localparam int CSB2FALCON_AW        = 2;
  localparam int RSP_RDAT_LSB         = 0;
  localparam int RSP_RDAT_MSB         = 31;
  localparam int RSP_ERROR_BIT        = 32;
  localparam int RSP_IS_WRITE_ACK_BIT = 33;
  typedef logic [CSB2FALCON_WIDTH-1:0] csb2falcon_rsp_t;
endpackage

// File: rtl/nv_nvdla_csb_master_csb2falcon_fifo_flopram_4x34.sv
// nv_nvdla_csb_master_csb2falcon_fifo_flopram_4x34: flop RAM, synchronous write, combinational read
// Ports: clk; we/wa/di write port (no input register); ra address, dout read data.
module nv_nvdla_csb_master_csb2falcon_fifo_flopram_4x34
  import nv_nvdla_csb_master_pkg::*;
#(
  parameter int DEPTH = CSB2FALCON_DEPTH,
  parameter int WIDTH = CSB2FALCON_WIDTH,
  parameter int AW    = CSB2FALCON_AW
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] di,
  input  logic [AW-1:0]    ra,
  output logic [WIDTH-1:0] dout
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) if (we) mem[wa] <= di;
  assign dout = mem[ra];
endmodule

// File: rtl/nv_nvdla_csb_master_csb2falcon_fifo.sv
// nv_nvdla_csb_master_csb2falcon_fifo: 4x34 valid/ready response FIFO, CSB side to falcon side
// Ports: clk, reset_ (async active-low); wr_req/wr_ready/wr_data producer side;
// rd_req/rd_ready/rd_data consumer side (rd_data is a combinational head read);
// pwrbus_ram_pd is ignored. Optional NV_NVDLA_CSB2FALCON_FIFO_STALL_STATS_EN adds
// wr_stall_cnt (saturating stall cycles) and max_count (occupancy high-watermark).
module nv_nvdla_csb_master_csb2falcon_fifo
  import nv_nvdla_csb_master_pkg::*;
#(
  parameter int DEPTH = CSB2FALCON_DEPTH,
  parameter int WIDTH = CSB2FALCON_WIDTH,
  parameter int AW    = CSB2FALCON_AW
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic             wr_req,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
  output logic             rd_req,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data,
  input  logic [31:0]      pwrbus_ram_pd
`ifdef NV_NVDLA_CSB2FALCON_FIFO_STALL_STATS_EN
  ,
  output logic [7:0]       wr_stall_cnt,
  output logic [AW:0]      max_count
`endif
);
  localparam int CW = AW + 1;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_next;
  logic          wr_accept, rd_accept;
  logic          unused_pd;
  assign unused_pd  = ^pwrbus_ram_pd;
  // Registered flags gate acceptance, so count can never leave 0..DEPTH.
  assign wr_accept  = wr_req & wr_ready;
  assign rd_accept  = rd_req & rd_ready;
  assign count_next = count + CW'(wr_accept) - CW'(rd_accept);
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      wr_ready <= 1'b1;
      rd_req   <= 1'b0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + AW'(1);
      if (rd_accept) rd_ptr <= rd_ptr + AW'(1);
      count    <= count_next;
      rd_req   <= count_next != '0;
      wr_ready <= count_next != CW'(DEPTH);
    end
  end
  nv_nvdla_csb_master_csb2falcon_fifo_flopram_4x34 #(
    .DEPTH(DEPTH),
    .WIDTH(WIDTH),
    .AW   (AW)
  ) u_ram (
    .clk (clk),
    .we  (wr_accept),
    .wa  (wr_ptr),
    .di  (wr_data),
    .ra  (rd_ptr),
    .dout(rd_data)
  );
`ifdef NV_NVDLA_CSB2FALCON_FIFO_STALL_STATS_EN
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      wr_stall_cnt <= '0;
      max_count    <= '0;
    end else begin
      if (wr_req && !wr_ready && wr_stall_cnt != 8'hff) wr_stall_cnt <= wr_stall_cnt + 8'd1;
      max_count <= (count_next > max_count) ? count_next : max_count;
    end
  end
`endif
endmodule

// File: tb/tb_nv_nvdla_csb_master_csb2falcon_fifo.sv
// tb_nv_nvdla_csb_master_csb2falcon_fifo: self-checking bench with queue reference model
module tb_nv_nvdla_csb_master_csb2falcon_fifo;
  logic        clk = 1'b0;
  logic        reset_ = 1'b1;
  logic        wr_req = 1'b0, rd_ready = 1'b0;
  logic        wr_ready, rd_req;
  logic [33:0] wr_data = '0;
  logic [33:0] rd_data;
  logic [31:0] pwrbus_ram_pd = '0;
`ifdef NV_NVDLA_CSB2FALCON_FIFO_STALL_STATS_EN
  logic [7:0]  wr_stall_cnt;
  logic [2:0]  max_count;
`endif
  int n_chk = 0, n_fail = 0;
  logic [33:0] q[$];

  nv_nvdla_csb_master_csb2falcon_fifo dut (
    .clk          (clk),
    .reset_       (reset_),
    .wr_req       (wr_req),
    .wr_ready     (wr_ready),
    .wr_data      (wr_data),
    .rd_req       (rd_req),
    .rd_ready     (rd_ready),
    .rd_data      (rd_data),
    .pwrbus_ram_pd(pwrbus_ram_pd)
`ifdef NV_NVDLA_CSB2FALCON_FIFO_STALL_STATS_EN
    ,
    .wr_stall_cnt (wr_stall_cnt),
    .max_count    (max_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [33:0] act, input logic [33:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model view: FIFO occupancy is the queue length; head is q[0].
  task automatic check_model();
    cmp("model_rd_req", rd_req, q.size() != 0);
    cmp("model_wr_ready", wr_ready, q.size() != 4);
    if (q.size() != 0) cmp("model_rd_data", rd_data, q[0]);
  endtask

  task automatic tick(input bit w, input logic [33:0] d, input bit r);
    int  n;
    bit  pop, push;
    wr_req = w; wr_data = d; rd_ready = r;
    @(posedge clk);
    n = q.size();
    pop  = r && n > 0;
    push = w && n < 4;
    if (pop) void'(q.pop_front());
    if (push) q.push_back(d);
    #1;
    check_model();
  endtask

  typedef struct {
    bit          w;
    logic [33:0] d;
    bit          r;
    bit          e_req;
    bit          e_rdy;
    bit          e_chk;
    logic [33:0] e_d;
  } vec_t;
  vec_t tv[11];

  initial begin
    bit          pend;
    bit          w, r;
    logic [33:0] d, pd;
    tv[0]  = '{1'b1, 34'd0, 1'b0, 1'b1, 1'b1, 1'b1, 34'd0};
    tv[1]  = '{1'b1, 34'd1, 1'b0, 1'b1, 1'b1, 1'b1, 34'd0};
    tv[2]  = '{1'b1, 34'd2, 1'b0, 1'b1, 1'b1, 1'b1, 34'd0};
    tv[3]  = '{1'b1, 34'd3, 1'b0, 1'b1, 1'b0, 1'b1, 34'd0};
    tv[4]  = '{1'b1, 34'd4, 1'b0, 1'b1, 1'b0, 1'b1, 34'd0};
    tv[5]  = '{1'b1, 34'd4, 1'b1, 1'b1, 1'b1, 1'b1, 34'd1};
    tv[6]  = '{1'b1, 34'd4, 1'b0, 1'b1, 1'b0, 1'b1, 34'd1};
    tv[7]  = '{1'b0, 34'd0, 1'b1, 1'b1, 1'b1, 1'b1, 34'd2};
    tv[8]  = '{1'b0, 34'd0, 1'b1, 1'b1, 1'b1, 1'b1, 34'd3};
    tv[9]  = '{1'b0, 34'd0, 1'b1, 1'b1, 1'b1, 1'b1, 34'd4};
    tv[10] = '{1'b0, 34'd0, 1'b1, 1'b0, 1'b1, 1'b0, 34'd0};

    #3 reset_ = 1'b0;
    #1;
    cmp("reset_rd_req", rd_req, 1'b0);
    cmp("reset_wr_ready", wr_ready, 1'b1);
`ifdef NV_NVDLA_CSB2FALCON_FIFO_STALL_STATS_EN
    cmp("reset_stall_cnt", wr_stall_cnt, 0);
    cmp("reset_max_count", max_count, 0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk) reset_ = 1'b1;

    for (int i = 0; i < 10; i++) tick(0, '0, 0);

    tick(1, 34'h1_DEAD_BEEF, 0);
    cmp("pass_rd_req", rd_req, 1'b1);
    cmp("pass_rd_data", rd_data, 34'h1_DEAD_BEEF);
    tick(0, '0, 1);
    cmp("pass_drained", rd_req, 1'b0);

    for (int i = 0; i < 11; i++) begin
      tick(tv[i].w, tv[i].d, tv[i].r);
      cmp($sformatf("vec%0d_rd_req", i), rd_req, tv[i].e_req);
      cmp($sformatf("vec%0d_wr_ready", i), wr_ready, tv[i].e_rdy);
      if (tv[i].e_chk) cmp($sformatf("vec%0d_rd_data", i), rd_data, tv[i].e_d);
    end

    for (int i = 0; i < 20; i++) begin
      d = 34'h2_0000_0000 + 34'(i * 17);
      tick(1, d, 1);
      cmp("wrap_rd_req", rd_req, 1'b1);
      cmp("wrap_wr_ready", wr_ready, 1'b1);
      cmp("wrap_rd_data", rd_data, d);
    end
    tick(0, '0, 1);
    cmp("wrap_drained", rd_req, 1'b0);

    tick(1, 34'h0_AAAA_0001, 0);
    tick(1, 34'h0_AAAA_0002, 0);
    tick(1, 34'h0_AAAA_0003, 0);
    wr_req = 1'b0;
    #2 reset_ = 1'b0;
    #1;
    cmp("midrst_rd_req", rd_req, 1'b0);
    cmp("midrst_wr_ready", wr_ready, 1'b1);
`ifdef NV_NVDLA_CSB2FALCON_FIFO_STALL_STATS_EN
    cmp("midrst_stall_cnt", wr_stall_cnt, 0);
    cmp("midrst_max_count", max_count, 0);
`endif
    q.delete();
    @(posedge clk);
    @(negedge clk) reset_ = 1'b1;
    tick(1, 34'h3_1234_5678, 0);
    cmp("midrst_readback", rd_data, 34'h3_1234_5678);
    tick(0, '0, 1);

    pend = 1'b0;
    pd = '0;
    for (int i = 0; i < 400; i++) begin
      if (pend) begin
        w = 1'b1; d = pd;
      end else begin
        w = ($urandom % 4) != 0;
        d = 34'({$urandom, $urandom});
      end
      r = (i < 200) ? (($urandom % 4) == 0) : (($urandom % 4) != 0);
      pend = w && !wr_ready;
      pd = d;
      tick(w, d, r);
    end
    for (int i = 0; i < 5; i++) tick(0, '0, 1);

`ifdef NV_NVDLA_CSB2FALCON_FIFO_STALL_STATS_EN
    for (int i = 0; i < 4; i++) tick(1, 34'(i), 0);
    for (int i = 0; i < 300; i++) tick(1, 34'h3_0000_0000, 0);
    cmp("stats_stall_cnt", wr_stall_cnt, 255);
    cmp("stats_max_count", max_count, 4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
